// File: rtl/wb_rr_arbiter_if.sv
// Wishbone B4 classic bundle between N requesting masters, the arbiter and one shared slave.
// The slave modport is the arbiter's view. The master modport is the view of the surrounding masters and slave.
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic [NUM_MASTERS-1:0]            wbm_cyc_i;
  logic [NUM_MASTERS-1:0]            wbm_stb_i;
  logic [NUM_MASTERS-1:0]            wbm_we_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] wbm_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] wbm_dat_i;
  logic [NUM_MASTERS*SEL_WIDTH-1:0]  wbm_sel_i;
  logic [DATA_WIDTH-1:0]             wbm_dat_o;
  logic [NUM_MASTERS-1:0]            wbm_ack_o;
  logic [NUM_MASTERS-1:0]            wbm_err_o;

  logic                              wbs_cyc_o;
  logic                              wbs_stb_o;
  logic                              wbs_we_o;
  logic [ADDR_WIDTH-1:0]             wbs_adr_o;
  logic [DATA_WIDTH-1:0]             wbs_dat_o;
  logic [SEL_WIDTH-1:0]              wbs_sel_o;
  logic [DATA_WIDTH-1:0]             wbs_dat_i;
  logic                              wbs_ack_i;
  logic                              wbs_err_i;

  logic [NUM_MASTERS-1:0]            grant_o;
  logic                              timeout_o;

  modport slave (
    input  wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_adr_i, wbm_dat_i, wbm_sel_i,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o,
    output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o, wbs_sel_o,
    output grant_o, timeout_o
  );

  modport master (
    output wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_adr_i, wbm_dat_i, wbm_sel_i,
    output wbs_dat_i, wbs_ack_i, wbs_err_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o,
    input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o, wbs_sel_o,
    input  grant_o, timeout_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter with per-cycle ownership: grant 1 cycle after cyc, and 1 idle cycle between owners.
// Non-owners stall on held cyc. A watchdog aborts a stalled owner with err, then holds the slave off until the owner drops cyc.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic           clk_i,
  input  logic           rst_i,
  wb_rr_arbiter_if.slave bus
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IW        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW        = $clog2(TIMEOUT + 2);

  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_MASTERS - 1);
  localparam logic [CW-1:0] TO_LIMIT  = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    ABORT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          last_q, last_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic                   pick_found;
  logic [IW-1:0]          pick_idx;

  logic                   own_cyc;
  logic                   own_stb;
  logic                   own_we;
  logic [ADDR_WIDTH-1:0]  own_adr;
  logic [DATA_WIDTH-1:0]  own_dat;
  logic [SEL_WIDTH-1:0]   own_sel;

  logic                   stall;
  logic                   abort_hit;

  // While not idle, last_q is the current owner's index.
  always_comb begin
    own_cyc = bus.wbm_cyc_i[last_q];
    own_stb = bus.wbm_stb_i[last_q];
    own_we  = bus.wbm_we_i[last_q];
    own_adr = bus.wbm_adr_i[int'(last_q)*ADDR_WIDTH +: ADDR_WIDTH];
    own_dat = bus.wbm_dat_i[int'(last_q)*DATA_WIDTH +: DATA_WIDTH];
    own_sel = bus.wbm_sel_i[int'(last_q)*SEL_WIDTH +: SEL_WIDTH];
  end

  // Scan from last_q+1 so the previous owner is considered last.
  always_comb begin
    int j;
    pick_found = 1'b0;
    pick_idx   = last_q;
    j          = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      j = (int'(last_q) + i) % NUM_MASTERS;
      if (!pick_found && bus.wbm_cyc_i[j]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(j);
      end
    end
  end

  assign stall     = (state_q == OWNED) && own_cyc && own_stb &&
                     !bus.wbs_ack_i && !bus.wbs_err_i;
  assign abort_hit = (TIMEOUT > 0) && stall && (cnt_q == TO_LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= LAST_INIT;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OWNED;
          last_d  = pick_idx;
          grant_d = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      OWNED: begin
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (abort_hit) begin
          state_d = ABORT;
        end else if (stall) begin
          // Saturates at the limit, so the count also stops when the watchdog is disabled.
          cnt_d = (cnt_q == TO_LIMIT) ? cnt_q : cnt_q + 1'b1;
        end
      end
      ABORT: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    bus.wbs_cyc_o = 1'b0;
    bus.wbs_stb_o = 1'b0;
    bus.wbs_we_o  = 1'b0;
    bus.wbs_adr_o = '0;
    bus.wbs_dat_o = '0;
    bus.wbs_sel_o = '0;
    bus.wbm_ack_o = '0;
    bus.wbm_err_o = '0;
    bus.timeout_o = 1'b0;
    unique case (state_q)
      OWNED: begin
        bus.wbs_cyc_o         = own_cyc;
        bus.wbs_stb_o         = own_cyc & own_stb;
        bus.wbs_we_o          = own_we;
        bus.wbs_adr_o         = own_adr;
        bus.wbs_dat_o         = own_dat;
        bus.wbs_sel_o         = own_sel;
        bus.wbm_ack_o[last_q] = bus.wbs_ack_i;
        bus.wbm_err_o[last_q] = bus.wbs_err_i;
      end
      ABORT: begin
        bus.wbm_err_o[last_q] = 1'b1;
        bus.timeout_o         = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.wbm_dat_o = bus.wbs_dat_i;
  assign bus.grant_o   = grant_q;

endmodule
